// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: FSM states,
// access-length codes, latched request payload and the byte-count decoder.
package mem_ctrl_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned CNT_WIDTH      = 3;

    localparam logic [1:0] LEN_BYTE          = 2'd0;
    localparam logic [1:0] LEN_HALF          = 2'd1;
    localparam logic [1:0] LEN_WORD          = 2'd3;
    localparam logic [1:0] IO_PREFIX_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_LSB    = 1'b1
    } req_t;

    // Request latched at accept time.
    typedef struct packed {
        req_t                  id;
        logic [CNT_WIDTH-1:0]  nbytes;
        logic [DATA_WIDTH-1:0] wdata;
    } req_s;

    // The reserved length code 2 is served as a full word.
    function automatic logic [CNT_WIDTH-1:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return CNT_WIDTH'(1);
            LEN_HALF: return CNT_WIDTH'(2);
            default:  return CNT_WIDTH'(4);
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response handshakes of the icache and LSB ports plus the
// byte-wide RAM/IO bus, as seen from the memory controller.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                      valid_from_icache;
    logic [MEM_ADDR_WIDTH-1:0] addr_from_icache;
    logic                      valid_to_icache;
    logic [DATA_WIDTH-1:0]     data_to_icache;

    logic                      valid_from_lsb;
    logic                      wr_from_lsb;
    logic [MEM_ADDR_WIDTH-1:0] addr_from_lsb;
    logic [1:0]                len_from_lsb;
    logic [DATA_WIDTH-1:0]     data_from_lsb;
    logic                      valid_to_lsb;
    logic [DATA_WIDTH-1:0]     data_to_lsb;

    logic [BYTE_WIDTH-1:0]     mem_din;
    logic [BYTE_WIDTH-1:0]     mem_dout;
    logic [MEM_ADDR_WIDTH-1:0] mem_a;
    logic                      mem_wr;
    logic                      io_buffer_full;

    modport slave (
        input  valid_from_icache, addr_from_icache,
        input  valid_from_lsb, wr_from_lsb, addr_from_lsb, len_from_lsb, data_from_lsb,
        input  mem_din, io_buffer_full,
        output valid_to_icache, data_to_icache, valid_to_lsb, data_to_lsb,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output valid_from_icache, addr_from_icache,
        output valid_from_lsb, wr_from_lsb, addr_from_lsb, len_from_lsb, data_from_lsb,
        output mem_din, io_buffer_full,
        input  valid_to_icache, data_to_icache, valid_to_lsb, data_to_lsb,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates icache fetches and LSB loads/stores onto a
// byte-wide RAM/IO bus, assembling reads and serialising writes per byte.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter logic [1:0]  IO_PREFIX  = IO_PREFIX_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);

    state_t                  state_q,    state_n;
    req_s                    req_q,      req_n;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_n;
    logic [ADDR_WIDTH-1:0]   mem_a_q,    mem_a_n;
    logic [CNT_WIDTH-1:0]    issue_q,    issue_n;
    logic [CNT_WIDTH-1:0]    cap_q,      cap_n;
    logic [DATA_WIDTH-1:0]   rbuf_q,     rbuf_n;
    logic                    restart_q,  restart_n;
    logic [BYTE_WIDTH-1:0]   mem_dout_q, mem_dout_n;
    logic                    vic_q,      vic_n;
    logic                    vlsb_q,     vlsb_n;
    logic [DATA_WIDTH-1:0]   dic_q,      dic_n;
    logic [DATA_WIDTH-1:0]   dlsb_q,     dlsb_n;

    logic       acc_lsb_c, acc_ic_c, io_stall_c;
    logic [1:0] cap_idx_c, wr_idx_c;

    // A port still showing its done pulse is holding a stale valid.
    assign acc_lsb_c  = bus.valid_from_lsb    && !vlsb_q;
    assign acc_ic_c   = bus.valid_from_icache && !vic_q;
    assign io_stall_c = (addr_q[17:16] == IO_PREFIX) && bus.io_buffer_full;
    assign cap_idx_c  = 2'(cap_q - CNT_WIDTH'(1));
    assign wr_idx_c   = 2'(issue_q + CNT_WIDTH'(1));

    assign bus.mem_wr          = rdy && (state_q == ST_WRITE) && !io_stall_c;
    assign bus.mem_a           = mem_a_q;
    assign bus.mem_dout        = mem_dout_q;
    assign bus.valid_to_icache = vic_q;
    assign bus.data_to_icache  = dic_q;
    assign bus.valid_to_lsb    = vlsb_q;
    assign bus.data_to_lsb     = dlsb_q;

    // Next-state and datapath logic.
    always_comb begin
        state_n    = state_q;
        req_n      = req_q;
        addr_n     = addr_q;
        mem_a_n    = mem_a_q;
        issue_n    = issue_q;
        cap_n      = cap_q;
        rbuf_n     = rbuf_q;
        restart_n  = restart_q;
        mem_dout_n = mem_dout_q;
        vic_n      = vic_q;
        vlsb_n     = vlsb_q;
        dic_n      = dic_q;
        dlsb_n     = dlsb_q;

        if (!rdy) begin
            // Bytes seen while frozen are untrustworthy; re-run the read.
            if (state_q == ST_READ) restart_n = 1'b1;
        end else begin
            vic_n  = 1'b0;
            vlsb_n = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc_lsb_c) begin
                        req_n.id     = REQ_LSB;
                        req_n.nbytes = len_to_bytes(bus.len_from_lsb);
                        req_n.wdata  = bus.data_from_lsb;
                        addr_n       = bus.addr_from_lsb;
                        mem_a_n      = bus.addr_from_lsb;
                        if (bus.wr_from_lsb) begin
                            mem_dout_n = bus.data_from_lsb[BYTE_WIDTH-1:0];
                            state_n    = ST_WRITE;
                        end else begin
                            state_n    = ST_READ;
                        end
                    end else if (acc_ic_c) begin
                        req_n.id     = REQ_ICACHE;
                        req_n.nbytes = CNT_WIDTH'(4);
                        req_n.wdata  = '0;
                        addr_n       = bus.addr_from_icache;
                        mem_a_n      = bus.addr_from_icache;
                        state_n      = ST_READ;
                    end
                    if (acc_lsb_c || acc_ic_c) begin
                        issue_n   = '0;
                        cap_n     = '0;
                        rbuf_n    = '0;
                        restart_n = 1'b0;
                    end
                end

                ST_READ: begin
                    if (restart_q) begin
                        restart_n = 1'b0;
                        mem_a_n   = addr_q;
                        issue_n   = '0;
                        cap_n     = '0;
                        rbuf_n    = '0;
                    end else begin
                        if (issue_q < req_q.nbytes - CNT_WIDTH'(1)) begin
                            issue_n = issue_q + CNT_WIDTH'(1);
                            mem_a_n = mem_a_q + ADDR_WIDTH'(1);
                        end
                        // mem_din lags mem_a by one cycle, so capture trails issue.
                        if (cap_q != '0) rbuf_n[{cap_idx_c, 3'b000} +: BYTE_WIDTH] = bus.mem_din;
                        cap_n = cap_q + CNT_WIDTH'(1);
                        if (cap_q == req_q.nbytes) begin
                            state_n = ST_IDLE;
                            if (req_q.id == REQ_LSB) begin
                                vlsb_n = 1'b1;
                                dlsb_n = rbuf_n;
                            end else begin
                                vic_n  = 1'b1;
                                dic_n  = rbuf_n;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (!io_stall_c) begin
                        if (issue_q == req_q.nbytes - CNT_WIDTH'(1)) begin
                            state_n = ST_IDLE;
                            vlsb_n  = 1'b1;
                        end else begin
                            issue_n    = issue_q + CNT_WIDTH'(1);
                            mem_a_n    = mem_a_q + ADDR_WIDTH'(1);
                            mem_dout_n = req_q.wdata[{wr_idx_c, 3'b000} +: BYTE_WIDTH];
                        end
                    end
                end

                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            addr_q     <= '0;
            mem_a_q    <= '0;
            issue_q    <= '0;
            cap_q      <= '0;
            rbuf_q     <= '0;
            restart_q  <= 1'b0;
            mem_dout_q <= '0;
            vic_q      <= 1'b0;
            vlsb_q     <= 1'b0;
            dic_q      <= '0;
            dlsb_q     <= '0;
        end else begin
            state_q    <= state_n;
            req_q      <= req_n;
            addr_q     <= addr_n;
            mem_a_q    <= mem_a_n;
            issue_q    <= issue_n;
            cap_q      <= cap_n;
            rbuf_q     <= rbuf_n;
            restart_q  <= restart_n;
            mem_dout_q <= mem_dout_n;
            vic_q      <= vic_n;
            vlsb_q     <= vlsb_n;
            dic_q      <= dic_n;
            dlsb_q     <= dlsb_n;
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller: the responder end of the instruction-fetch request/response protocol, serving the instruction cache.
- Also serves load/store requests from the LSB.
- Arbitrates the two requesters onto the single byte-wide RAM/IO bus and returns results.
- Assembles multi-byte reads and serialises multi-byte writes, one byte per cycle.

Parameters:
ADDR_WIDTH, 32, width of all address ports
IO_PREFIX, 2'b11, value of addr[17:16] marking an IO-mapped address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; low = freeze
valid_from_icache  in  1  fetch request; held high until valid_to_icache seen
addr_from_icache  in  32  fetch address, stable while request high
valid_to_icache  out  1  one-cycle done pulse
data_to_icache  out  32  fetched word, valid while valid_to_icache high
valid_from_lsb  in  1  load/store request; held until valid_to_lsb
wr_from_lsb  in  1  1 = store, 0 = load
addr_from_lsb  in  32  byte address
len_from_lsb  in  2  0 = byte, 1 = half, 3 = word (2 is illegal, treated as 3)
data_from_lsb  in  32  store data, little-endian
valid_to_lsb  out  1  one-cycle done pulse
data_to_lsb  out  32  load data, zero-extended
mem_din  in  8  RAM read byte; reflects mem_a from the previous cycle
mem_dout  out  8  write byte
mem_a  out  32  byte address
mem_wr  out  1  1 = write this cycle
io_buffer_full  in  1  IO write buffer cannot accept

Behaviour:
- Reset (async, any state, mid-transfer included): state IDLE; all outputs 0; counters 0; any in-flight request dropped.
- rdy low: all registers hold; mem_wr forced 0 combinationally.
  - If a READ was in progress, the first rdy-high edge restarts it from byte 0: mem_a <= base, capture counter cleared.
- States: IDLE, READ, WRITE.
- IDLE accept:
  - LSB has fixed priority over icache.
  - A port whose done output is high this cycle is not eligible, because its valid is still high for one cycle.
  - Accept latches addr, n = len+1 bytes (icache always 4), wdata and requester id.
  - Read: mem_a <= addr, go to READ.
  - Write: go to WRITE.
  - The done pulse register clears on the next edge.
- READ:
  - Issue counter i steps mem_a through addr..addr+n-1 (one per edge after accept), then holds.
  - Capture starts on the second edge after accept: byte k = mem_din, placed at bits [8k+7:8k].
  - After the edge capturing byte n-1: the requester's data_to_* is loaded and valid_to_* is set for exactly one cycle, state returns to IDLE.
  - Latency: done is high in cycle n+2 after the accept edge (word = cycle 6, byte = cycle 3).
  - Upper bytes beyond n are 0.
- WRITE:
  - Each cycle drives mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr = 1.
  - If addr[17:16]==IO_PREFIX and io_buffer_full: mem_wr = 0 and i does not advance.
  - After byte n-1 is written, valid_to_lsb is high the next cycle, then IDLE.
  - Stores never come from icache.
- Outside WRITE, mem_wr = 0; mem_a holds its last value.
- Requests arriving while busy wait; a requester changing addr mid-request is illegal and unchecked.
- Address arithmetic is modulo 2^32.
- Done pulses of the two ports never coincide.

Decomposition:
- Shared include (alongside DATA_RANGE/ADDR_RANGE): state encodings, LEN_BYTE/LEN_HALF/LEN_WORD constants, IO prefix.
- No sub-module. Arbitration and the byte-lane shifter stay inline; the design is one FSM plus two counters.

Test Plan:
- Icache fetch 0x00000004, RAM bytes 13,05,00,00 -> valid_to_icache high exactly one cycle, in cycle 6 after accept, data_to_icache=0x00000513; no re-accept in the done cycle.
- Simultaneous icache 0x100 and LSB word load 0x2000 -> LSB served first (done cycle 6), icache accepted the cycle after LSB done, done 6 cycles later.
- LSB half store 0xBEEF to 0x1001 -> mem_wr high 2 cycles, (0x1001,EF), (0x1002,BE); valid_to_lsb next cycle; RAM reads back 0x0000BEEF.
- Byte store 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr 0 for those cycles, then one write, then done.
- rdy low 2 cycles mid word-read -> mem_wr stays 0, read restarts from byte 0, correct word returned; byte load to 0x3 returns 0x000000xx.
- rst asserted mid word-write (no clock edge) -> all outputs 0 immediately; next request is served normally.
